// File: rtl/ym_regif_pkg.sv
// ym_regif_pkg: shared constants and types for the YM CPU register interface.
package ym_regif_pkg;

  // SDA[0] selects between the address port and the data port of a bank
  localparam logic ADDR_PORT = 1'b0;
  localparam logic DATA_PORT = 1'b1;

  // Position of the busy flag inside the status byte
  localparam int STATUS_BUSY_BIT = 7;

  // Bank-0 registers with side effects inside the interface itself
  localparam logic [7:0] DEFAULT_FLAG_CLR_ADDR = 8'h1C;
  localparam logic [7:0] DEFAULT_MASK_ADDR     = 8'h27;

  // Busy window state machine
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_e;

endpackage

// File: rtl/ym_busy_ctr.sv
// ym_busy_ctr: models the chip busy window after an accepted data write.
// A load starts a window of exactly BUSY_CYCLES cycles; loads during the
// window are ignored, so a dropped write can never stretch it.
module ym_busy_ctr
  import ym_regif_pkg::*;
#(
  parameter int BUSY_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam int            CW       = $clog2(BUSY_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  busy_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // State and counter registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: load on entry, count down, leave when decrementing from 1
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_BUSY;
          count_d = LOAD_VAL;
        end
      end
      ST_BUSY: begin
        if (count_q == ONE) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - ONE;
        end
      end
    endcase
  end

  // Busy output decoded straight from the registered state
  always_comb begin
    busy = (state_q == ST_BUSY);
  end

endmodule

// File: rtl/ym_regif.sv
// ym_regif: CPU-side register interface of the YM sound-chip models.
// Latches per-bank addresses, forwards accepted data writes as registered
// one-cycle strobes, keeps a readable shadow of every register, and owns
// the sticky status flags, the IRQ mask and the active-low interrupt.
module ym_regif
  import ym_regif_pkg::*;
#(
  parameter int         BANKS         = 2,
  parameter int         BUSY_CYCLES   = 32,
  parameter int         FLAG_W        = 7,
  parameter logic [7:0] FLAG_CLR_ADDR = DEFAULT_FLAG_CLR_ADDR,
  parameter logic [7:0] MASK_ADDR     = DEFAULT_MASK_ADDR,
  localparam int        BW            = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              PHI_S,
  input  logic              RESET,
  input  logic [BW:0]       SDA,
  input  logic [7:0]        SDD_IN,
  input  logic              CPU_WE,
  input  logic              CPU_RE,
  output logic [7:0]        SDD_OUT,
  output logic              REG_WE,
  output logic [BW-1:0]     REG_BANK,
  output logic [7:0]        REG_ADDR,
  output logic [7:0]        REG_DATA,
  input  logic [FLAG_W-1:0] FLAG_SET,
  output logic              BUSY,
  output logic              nIRQ
);

  localparam logic [BW:0] BANK_LIMIT = (BW + 1)'(BANKS);

  logic [7:0]        addr_latch_q [BANKS];
  logic [7:0]        addr_latch_d [BANKS];
  logic [7:0]        shadow_q     [BANKS][256];
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] mask_q, mask_d;
  logic [FLAG_W-1:0] flag_clr;
  logic              nirq_q, nirq_d;
  logic              reg_we_q, reg_we_d;
  logic [BW-1:0]     reg_bank_q, reg_bank_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic [7:0]        reg_data_q, reg_data_d;
  logic [7:0]        sdd_out_q, sdd_out_d;

  logic              port_sel;
  logic [BW-1:0]     bank;
  logic [BW-1:0]     bank_idx;
  logic              bank_ok;
  logic              addr_wr;
  logic              data_accept;
  logic              rd_en;
  logic [7:0]        cur_addr;
  logic [7:0]        status_byte;
  logic              busy;

  // Decode the bus cycle: port, bank, and whether a data write is taken
  always_comb begin
    port_sel    = SDA[0];
    bank        = SDA[BW:1];
    bank_ok     = ({1'b0, bank} < BANK_LIMIT);
    bank_idx    = bank_ok ? bank : '0;
    cur_addr    = addr_latch_q[bank_idx];
    addr_wr     = CPU_WE && (port_sel == ADDR_PORT) && bank_ok;
    data_accept = CPU_WE && (port_sel == DATA_PORT) && bank_ok && !busy;
    rd_en       = CPU_RE && !CPU_WE;
  end

  ym_busy_ctr #(
    .BUSY_CYCLES(BUSY_CYCLES)
  ) u_busy_ctr (
    .clk (PHI_S),
    .rst (RESET),
    .load(data_accept),
    .busy(busy)
  );

  // Status byte: busy in the top bit, sticky flags in the low bits
  always_comb begin
    status_byte                  = '0;
    status_byte[FLAG_W-1:0]      = flags_q;
    status_byte[STATUS_BUSY_BIT] = busy;
  end

  // Next values for address latches, flags, mask, strobes and read data
  always_comb begin
    addr_latch_d = addr_latch_q;
    mask_d       = mask_q;
    flag_clr     = '0;
    reg_we_d     = 1'b0;
    reg_bank_d   = reg_bank_q;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    sdd_out_d    = sdd_out_q;

    if (addr_wr) begin
      addr_latch_d[bank_idx] = SDD_IN;
    end

    if (data_accept) begin
      reg_we_d   = 1'b1;
      reg_bank_d = bank;
      reg_addr_d = cur_addr;
      reg_data_d = SDD_IN;
      if (bank == '0 && cur_addr == MASK_ADDR) begin
        mask_d = SDD_IN[FLAG_W-1:0];
      end
      if (bank == '0 && cur_addr == FLAG_CLR_ADDR) begin
        flag_clr = SDD_IN[FLAG_W-1:0];
      end
    end

    if (rd_en) begin
      if (port_sel == ADDR_PORT) begin
        sdd_out_d = status_byte;
      end else if (bank_ok) begin
        sdd_out_d = shadow_q[bank_idx][cur_addr];
      end else begin
        sdd_out_d = 8'hFF;
      end
    end

    flags_d = (flags_q & ~flag_clr) | FLAG_SET;
    nirq_d  = ~|(flags_d & mask_q);
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge PHI_S) begin
    if (RESET) begin
      for (int b = 0; b < BANKS; b++) begin
        addr_latch_q[b] <= '0;
      end
      flags_q    <= '0;
      mask_q     <= '0;
      nirq_q     <= 1'b1;
      reg_we_q   <= 1'b0;
      reg_bank_q <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      sdd_out_q  <= '0;
    end else begin
      addr_latch_q <= addr_latch_d;
      flags_q      <= flags_d;
      mask_q       <= mask_d;
      nirq_q       <= nirq_d;
      reg_we_q     <= reg_we_d;
      reg_bank_q   <= reg_bank_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      sdd_out_q    <= sdd_out_d;
    end
  end

  // Shadow register file: written only by accepted data writes
  always_ff @(posedge PHI_S) begin
    if (RESET) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int a = 0; a < 256; a++) begin
          shadow_q[b][a] <= '0;
        end
      end
    end else if (data_accept) begin
      shadow_q[bank_idx][cur_addr] <= SDD_IN;
    end
  end

  assign SDD_OUT  = sdd_out_q;
  assign REG_WE   = reg_we_q;
  assign REG_BANK = reg_bank_q;
  assign REG_ADDR = reg_addr_q;
  assign REG_DATA = reg_data_q;
  assign BUSY     = busy;
  assign nIRQ     = nirq_q;

endmodule
